rc4_stream_xor: RTL



---
 rtl/rc4_stream_xor_if.sv | 35 +++
 rtl/rc4_stream_xor.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rc4_stream_xor_if.sv
// Handshake and control bundle for the RC4 keystream-XOR datapath.
// The master side drives stimulus; the slave side is the datapath.
interface rc4_stream_xor_if #(
    parameter int BYTES    = 1,
    parameter int KS_DEPTH = 16,
    parameter int CNT_W    = 16
);
    localparam int LW = $clog2(KS_DEPTH) + 1;

    logic                 start;
    logic [CNT_W-1:0]     msg_len;
    logic                 bypass;
    logic [7:0]           ks_byte;
    logic                 ks_valid;
    logic                 ks_ready;
    logic [BYTES*8-1:0]   data_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [BYTES*8-1:0]   data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic [LW-1:0]        ks_level;

    modport master (
        output start, msg_len, bypass, ks_byte, ks_valid, data_in, in_valid, out_ready,
        input  ks_ready, in_ready, data_out, out_valid, busy, done, ks_level
    );

    modport slave (
        input  start, msg_len, bypass, ks_byte, ks_valid, data_in, in_valid, out_ready,
        output ks_ready, in_ready, data_out, out_valid, busy, done, ks_level
    );
endinterface

// File: rtl/rc4_stream_xor.sv
// Keystream FIFO plus message-framed multi-byte XOR stage with valid/ready on
// keystream, input and output. Keystream survives across messages until rst.
module rc4_stream_xor #(
    parameter int BYTES    = 1,
    parameter int KS_DEPTH = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    rc4_stream_xor_if.slave   bus
);
    localparam int AW = $clog2(KS_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = BYTES * 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              bypass_reg, bypass_next;
    logic              done_reg, done_next;
    logic              out_valid_reg, out_valid_next;
    logic [DW-1:0]     data_out_reg, data_out_next;

    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg, level_next;
    logic [7:0]        ks_mem [KS_DEPTH];
    logic [DW-1:0]     ks_word;

    logic              ks_ready_int, in_ready_int;
    logic              push, pop, accept, have_ks;

    // All full/empty decisions look only at the start-of-cycle level.
    assign have_ks      = level_reg >= LW'(BYTES);
    assign ks_ready_int = !rst && (level_reg < LW'(KS_DEPTH));
    assign in_ready_int = !rst && (state_reg == RUN) && (bypass_reg || have_ks)
                          && (!out_valid_reg || bus.out_ready);
    assign push         = bus.ks_valid && ks_ready_int;
    assign accept       = bus.in_valid && in_ready_int;
    assign pop          = accept && !bypass_reg;

    // Byte k of the beat pairs with the k-th oldest keystream byte.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_ks_word
            assign ks_word[8*gi +: 8] = ks_mem[rd_ptr_reg + AW'(gi)];
        end
    endgenerate

    assign level_next = level_reg + LW'(push) - (pop ? LW'(BYTES) : '0);

    always_ff @(posedge clk) begin
        if (push) begin
            ks_mem[wr_ptr_reg] <= bus.ks_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(BYTES);
            end
            level_reg <= level_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bypass_next    = bypass_reg;
        done_next      = 1'b0;
        out_valid_next = out_valid_reg;
        data_out_next  = data_out_reg;

        if (accept) begin
            out_valid_next = 1'b1;
            data_out_next  = bus.data_in ^ (bypass_reg ? '0 : ks_word);
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.msg_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        cnt_next    = bus.msg_len;
                        bypass_next = bus.bypass;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only the final beat can be sitting in the output register here.
                if (out_valid_reg && bus.out_ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bypass_reg    <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bypass_reg    <= bypass_next;
            done_reg      <= done_next;
            out_valid_reg <= out_valid_next;
            data_out_reg  <= data_out_next;
        end
    end

    // Outputs are forced quiet while rst is high so an aborted beat never escapes.
    assign bus.ks_ready  = ks_ready_int;
    assign bus.in_ready  = in_ready_int;
    assign bus.data_out  = rst ? '0 : data_out_reg;
    assign bus.out_valid = !rst && out_valid_reg;
    assign bus.done      = !rst && done_reg;
    assign bus.busy      = !rst && (state_reg != IDLE);
    assign bus.ks_level  = level_reg;
endmodule
